posit_stream_decoder: RTL and testbench

// - Consumer end of the packed-posit path: accepts packed posits on a valid/ready stream and emits unpacked fields.
// - Emitted fields: sign, zero/inf flags, signed combined exponent, left-aligned fraction.
// - Sits between packed-posit storage/transport and arithmetic units that work on unpacked operands.
// - Two-stage pipeline with full backpressure; one posit per cycle sustained throughput.

---
 rtl/posit_decode_pkg.sv | 27 ++
 rtl/posit_regime_count.sv | 35 +++
 rtl/posit_stream_decoder.sv | 135 +++++++++++++
 tb/tb_posit_stream_decoder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_decode_pkg.sv
// Shared sizing helpers and the unpacked-posit record for the posit decode path.
// Default build configuration constants live here; the top can be overridden per instance.
package posit_decode_pkg;

  localparam int POSIT_WIDTH = 8;
  localparam int POSIT_ES    = 1;

  function automatic int exp_w(input int width, input int es);
    return $clog2(width) + es + 1;
  endfunction

  function automatic int frac_w(input int width, input int es);
    return width - 3 - es;
  endfunction

  localparam int EXP_W  = exp_w(POSIT_WIDTH, POSIT_ES);
  localparam int FRAC_W = frac_w(POSIT_WIDTH, POSIT_ES);

  typedef struct packed {
    logic                     sign;
    logic                     zero;
    logic                     inf;
    logic signed [EXP_W-1:0]  exp;
    logic        [FRAC_W-1:0] frac;
  } Unpacked;

endpackage

// File: rtl/posit_regime_count.sv
// Combinational regime decoder: measures the leading run of identical bits in the
// posit magnitude (sign bit removed) and left-aligns the bits after the run terminator.
module posit_regime_count #(
  parameter  int WIDTH = 8,
  localparam int RW    = $clog2(WIDTH),
  localparam int MW    = WIDTH - 1,
  localparam int REMW  = WIDTH - 3
) (
  input  logic [MW-1:0]   i_mag,
  output logic [RW-1:0]   o_run,
  output logic            o_pol,
  output logic [REMW-1:0] o_rem
);

  logic          w_found;
  logic [RW:0]   w_shift;

  assign o_pol = i_mag[MW-1];

  always_comb begin
    o_run   = RW'(MW);
    w_found = 1'b0;
    for (int i = MW - 2; i >= 0; i--) begin
      if (!w_found && (i_mag[i] != o_pol)) begin
        o_run   = RW'(MW - 1 - i);
        w_found = 1'b1;
      end
    end
  end

  // Drop run plus terminator; zeros shift in, so bits past the LSB read as 0.
  assign w_shift = {1'b0, o_run} + 1'b1;
  assign o_rem   = REMW'((i_mag << w_shift) >> (MW - REMW));

endmodule

// File: rtl/posit_stream_decoder.sv
// Valid/ready posit unpacker: stage 1 takes sign and magnitude, stage 2 extracts regime/exponent/fraction.
// Define POSIT_DECODE_OUT_REG_EN to add a third output register stage (latency 3).
module posit_stream_decoder
  import posit_decode_pkg::*;
#(
  parameter  int WIDTH = POSIT_WIDTH,
  parameter  int ES    = POSIT_ES,
  localparam int EW    = exp_w(WIDTH, ES),
  localparam int FW    = frac_w(WIDTH, ES)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic                 out_inf,
  output logic signed [EW-1:0] out_exp,
  output logic [FW-1:0]        out_frac
);

  localparam int RW = $clog2(WIDTH);

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 inf;
    logic signed [EW-1:0] exp;
    logic [FW-1:0]        frac;
  } unpacked_t;

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic             r_s1_zero;
  logic             r_s1_inf;
  logic [WIDTH-2:0] r_s1_mag;
  logic             r_s2_valid;
  unpacked_t        r_s2;

  logic             w_s1_en;
  logic             w_s2_en;
  logic [RW-1:0]    w_run;
  logic             w_pol;
  logic [WIDTH-4:0] w_rem;
  logic signed [EW-1:0] w_run_ext;
  logic signed [EW-1:0] w_k;
  logic signed [EW-1:0] w_exp;
  unpacked_t        w_fields;
  unpacked_t        w_out;

  posit_regime_count #(.WIDTH(WIDTH)) u_regime (
    .i_mag (r_s1_mag),
    .o_run (w_run),
    .o_pol (w_pol),
    .o_rem (w_rem)
  );

  assign w_run_ext = EW'(w_run);
  assign w_k       = w_pol ? (w_run_ext - EW'(1)) : -w_run_ext;
  assign w_exp     = (w_k <<< ES) + EW'(w_rem[WIDTH-4 -: ES]);

  always_comb begin
    w_fields.sign = r_s1_sign;
    w_fields.zero = r_s1_zero;
    w_fields.inf  = r_s1_inf;
    w_fields.exp  = (r_s1_zero || r_s1_inf) ? '0 : w_exp;
    w_fields.frac = (r_s1_zero || r_s1_inf) ? '0 : w_rem[FW-1:0];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_mag   <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      r_s1_sign  <= in_bits[WIDTH-1];
      r_s1_zero  <= (in_bits == '0);
      r_s1_inf   <= (in_bits == {1'b1, {(WIDTH-1){1'b0}}});
      r_s1_mag   <= (WIDTH-1)'(in_bits[WIDTH-1] ? -in_bits : in_bits);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2       <= w_fields;
    end
  end

`ifdef POSIT_DECODE_OUT_REG_EN
  logic      r_s3_valid;
  unpacked_t r_s3;
  logic      w_s3_en;

  assign w_s3_en = !r_s3_valid || out_ready;
  assign w_s2_en = !r_s2_valid || w_s3_en;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_s3_valid <= 1'b0;
      r_s3       <= '0;
    end else if (w_s3_en) begin
      r_s3_valid <= r_s2_valid;
      r_s3       <= r_s2;
    end
  end

  assign out_valid = r_s3_valid;
  assign w_out     = r_s3;
`else
  assign w_s2_en   = !r_s2_valid || out_ready;
  assign out_valid = r_s2_valid;
  assign w_out     = r_s2;
`endif

  // A stage advances when it is empty or the stage after it advances.
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = resetn && w_s1_en;

  assign out_sign = w_out.sign;
  assign out_zero = w_out.zero;
  assign out_inf  = w_out.inf;
  assign out_exp  = w_out.exp;
  assign out_frac = w_out.frac;

endmodule

// File: tb/tb_posit_stream_decoder.sv
// Self-checking bench for posit_stream_decoder: fixed vectors, stream/stall/reset sequences,
// and randomized traffic scored against an arithmetic reference decoder.
module tb_posit_stream_decoder;
  import posit_decode_pkg::*;

  localparam int W  = POSIT_WIDTH;
  localparam int ES = POSIT_ES;
  localparam int EW = EXP_W;
  localparam int FW = FRAC_W;
`ifdef POSIT_DECODE_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                 clock = 1'b0;
  logic                 resetn = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [W-1:0]         in_bits = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 out_sign;
  logic                 out_zero;
  logic                 out_inf;
  logic signed [EW-1:0] out_exp;
  logic [FW-1:0]        out_frac;

  int total = 0;
  int bad   = 0;
  int out_seen = 0;
  Unpacked exp_q[$];
  logic    hold = 1'b0;
  Unpacked held;

  typedef struct {
    logic [W-1:0] bits;
    int sign;
    int zero;
    int inf;
    int expv;
    int frac;
  } vec_t;
  vec_t vecs[9];

  posit_stream_decoder dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_inf   (out_inf),
    .out_exp   (out_exp),
    .out_frac  (out_frac)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Reference decoder: walk the magnitude bit by bit, then left-align the leftover bits arithmetically.
  function automatic Unpacked model(input logic [W-1:0] b);
    Unpacked u;
    int mag, pol, r, i, n, val, k, e;
    u = '0;
    if (b == '0) begin
      u.zero = 1'b1;
      return u;
    end
    if (b == {1'b1, {(W-1){1'b0}}}) begin
      u.inf  = 1'b1;
      u.sign = 1'b1;
      return u;
    end
    u.sign = b[W-1];
    mag = u.sign ? ((1 << W) - int'(b)) : int'(b);
    pol = (mag >> (W - 2)) & 1;
    r = 0;
    i = W - 2;
    while (i >= 0 && ((mag >> i) & 1) == pol) begin
      r++;
      i--;
    end
    k = (pol == 1) ? r - 1 : -r;
    n = (i > 0) ? i : 0;
    val = mag & ((1 << n) - 1);
    if (n >= W - 3) val = val >> (n - (W - 3));
    else            val = val << ((W - 3) - n);
    e = val >> FW;
    u.exp  = EW'(k * (1 << ES) + e);
    u.frac = FW'(val);
    return u;
  endfunction

  function automatic logic [31:0] pack_out();
    return 32'({out_sign, out_zero, out_inf, out_exp, out_frac});
  endfunction

  // Scoreboard: queue model results on input handshakes, compare on output handshakes.
  initial begin
    Unpacked m;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        exp_q.delete();
        hold = 1'b0;
        check("rst_in_ready_low", int'(in_ready), 0);
      end else begin
        if (hold) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_data", int'(pack_out()), int'(32'(held)));
        end
        if (out_valid && out_ready) begin
          out_seen++;
          $display("out %0d: sign=%0d zero=%0d inf=%0d exp=%0d frac=%h",
                   out_seen, out_sign, out_zero, out_inf, $signed(out_exp), out_frac);
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            m = exp_q.pop_front();
            check("mon_sign", int'(out_sign), int'(m.sign));
            check("mon_zero", int'(out_zero), int'(m.zero));
            check("mon_inf",  int'(out_inf),  int'(m.inf));
            check("mon_exp",  int'($signed(out_exp)), int'($signed(m.exp)));
            check("mon_frac", int'(out_frac), int'(m.frac));
          end
          hold = 1'b0;
        end else if (out_valid) begin
          hold = 1'b1;
          held = Unpacked'(pack_out());
        end else begin
          hold = 1'b0;
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_bits));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, acc, outs, cyc, first_acc, first_out, bubbles, ready_low, saw_low, cnt;
    logic acc_now, out_now;

    vecs[0] = '{8'h40, 0, 0, 0,   0, 0};
    vecs[1] = '{8'h48, 0, 0, 0,   0, 8};
    vecs[2] = '{8'h50, 0, 0, 0,   1, 0};
    vecs[3] = '{8'hC0, 1, 0, 0,   0, 0};
    vecs[4] = '{8'h7F, 0, 0, 0,  12, 0};
    vecs[5] = '{8'h01, 0, 0, 0, -12, 0};
    vecs[6] = '{8'h81, 1, 0, 0,  12, 0};
    vecs[7] = '{8'h00, 0, 1, 0,   0, 0};
    vecs[8] = '{8'h80, 1, 0, 1,   0, 0};

    // Reset state
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_data", int'(pack_out()), 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    out_ready = 1'b1;

    // Fixed vectors, one at a time
    for (int v = 0; v < 9; v++) begin
      in_valid = 1'b1;
      in_bits  = vecs[v].bits;
      @(negedge clock);
      check("tbl_in_ready", int'(in_ready), 1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge clock);
        lat++;
      end while (!out_valid && lat < 20);
      $display("vec %0d: bits=%h exp=%0d frac=%h latency=%0d", v, vecs[v].bits, $signed(out_exp), out_frac, lat);
      check("tbl_latency", lat, LAT);
      check("tbl_sign", int'(out_sign), vecs[v].sign);
      check("tbl_zero", int'(out_zero), vecs[v].zero);
      check("tbl_inf",  int'(out_inf),  vecs[v].inf);
      check("tbl_exp",  int'($signed(out_exp)), vecs[v].expv);
      check("tbl_frac", int'(out_frac), vecs[v].frac);
      @(posedge clock); #1;
    end

    // Back-to-back 16 words under continuous ready
    acc = 0; outs = 0; cyc = 0; first_acc = -1; first_out = -1; bubbles = 0; ready_low = 0;
    in_valid = 1'b1;
    in_bits  = W'($urandom);
    while (outs < 16 && cyc < 200) begin
      @(negedge clock);
      acc_now = in_valid && in_ready;
      if (in_valid && !in_ready) ready_low++;
      if (acc_now) begin
        if (first_acc < 0) first_acc = cyc;
        acc++;
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        outs++;
      end else if (first_out >= 0) begin
        bubbles++;
      end
      @(posedge clock); #1;
      cyc++;
      if (acc_now) begin
        if (acc >= 16) in_valid = 1'b0;
        else           in_bits = W'($urandom);
      end
    end
    check("b2b_outputs", outs, 16);
    check("b2b_first_latency", first_out - first_acc, LAT);
    check("b2b_bubbles", bubbles, 0);
    check("b2b_in_ready_low", ready_low, 0);

    // Five-cycle output stall in the middle of a 20-word stream
    acc = 0; outs = 0; cyc = 0; saw_low = 0;
    in_valid = 1'b1;
    in_bits  = W'($urandom);
    while (outs < 20 && cyc < 300) begin
      @(negedge clock);
      acc_now = in_valid && in_ready;
      out_now = out_valid && out_ready;
      if (!out_ready) begin
        check("stall_in_ready", int'(in_ready), int'((acc - outs) < LAT));
        if (!in_ready && (acc - outs) == LAT) saw_low = 1;
      end
      if (acc_now) acc++;
      if (out_now) outs++;
      @(posedge clock); #1;
      cyc++;
      if (acc_now) begin
        if (acc >= 20) in_valid = 1'b0;
        else           in_bits = W'($urandom);
      end
      out_ready = !(cyc >= 6 && cyc < 11);
    end
    check("stall_outputs", outs, 20);
    check("stall_saw_ready_drop", saw_low, 1);

    // Reset with words in flight: they must never come out
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int j = 0; j < LAT; j++) begin
      in_bits = W'($urandom);
      @(negedge clock);
      check("midrst_accept", int'(in_ready), 1);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    resetn   = 1'b0;
    @(negedge clock);
    @(posedge clock); #1;
    resetn    = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(pack_out()), 0);
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clock);
      if (out_valid) cnt++;
    end
    check("midrst_no_emit", cnt, 0);
    @(posedge clock); #1;

    // Randomized traffic with random backpressure; corner values mixed in
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      acc_now = in_valid && in_ready;
      @(posedge clock); #1;
      if (!in_valid || acc_now) begin
        in_valid = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 9))
          0:       in_bits = '0;
          1:       in_bits = {1'b1, {(W-1){1'b0}}};
          2:       in_bits = W'($urandom_range(0, 3));
          3:       in_bits = ~W'($urandom_range(0, 3));
          default: in_bits = W'($urandom);
        endcase
      end
      out_ready = ($urandom_range(0, 9) < 6);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
